// File: rtl/line_tracker.sv
// line_tracker: line-following motor controller for the smart-car chassis.
//
// Sensor path: 2-FF synchroniser per sensor, then a per-bit filter that accepts a
// new level after FILT_LEN consecutive identical samples. The filtered vector is
// classified as NONE/LEFT/RIGHT/CENTER/ALL and drives an IDLE/FOLLOW/SEARCH/STOP
// state machine. Per-wheel duty and direction are latched at each PWM wrap and
// drive the H-bridge pins through a registered output stage.
//
// Optional feature (compile-time macro LINE_TRACKER_DEADTIME_EN): on a latched
// wheel-direction reversal, that wheel's pins are held low for DEAD_CYC clocks
// starting at the wrap.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   run enable; low forces IDLE
//   sens      in   raw sensor levels (1 = line seen), bit 0 leftmost, asynchronous
//   duty_base in   straight-ahead duty
//   duty_turn in   inner-wheel duty when correcting or searching
//   motor     out  {IN4,IN3,IN2,IN1}: IN1 left fwd, IN2 left rev, IN3 right rev, IN4 right fwd
//   state     out  0 IDLE, 1 FOLLOW, 2 SEARCH, 3 STOP
//   lost      out  high while in SEARCH
module line_tracker #(
    parameter int SENS_N   = 4,
    parameter int PWM_W    = 8,
    parameter int FILT_LEN = 4,
    parameter int LOST_CYC = 1000000,
    parameter int DEAD_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [SENS_N-1:0] sens,
    input  logic [PWM_W-1:0]  duty_base,
    input  logic [PWM_W-1:0]  duty_turn,
    output logic [3:0]        motor,
    output logic [1:0]        state,
    output logic              lost
);

    localparam int HALF = SENS_N / 2;
    localparam int FW   = $clog2(FILT_LEN + 1);
    localparam int LW   = (LOST_CYC > 1) ? $clog2(LOST_CYC) : 1;

    if (SENS_N < 2 || (SENS_N % 2) != 0 || FILT_LEN < 1 || LOST_CYC < 1 || DEAD_CYC < 0) begin : g_param_check
        $error("line_tracker: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FOLLOW = 2'd1, S_SEARCH = 2'd2, S_STOP = 2'd3} state_t;
    typedef enum logic [2:0] {C_NONE, C_LEFT, C_RIGHT, C_CENTER, C_ALL} cls_t;
    typedef enum logic {SIDE_L = 1'b0, SIDE_R = 1'b1} side_t;

    // ---------------- sensor synchroniser and filter ----------------
    logic [SENS_N-1:0] r_sync1, r_sync2, r_filt;
    logic [FW-1:0]     r_fcnt [SENS_N];

    // The counter tracks how many consecutive samples disagreed with the
    // filtered bit; the FILT_LEN-th such sample is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int unsigned i = 0; i < SENS_N; i++) r_fcnt[i] <= '0;
        end else begin
            r_sync1 <= sens;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < SENS_N; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FW'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FW'(1);
                end
            end
        end
    end

    // ---------------- position classification ----------------
    logic w_any_l, w_any_r;
    cls_t w_cls;

    always_comb begin
        w_any_l = |r_filt[HALF-1:0];
        w_any_r = |r_filt[SENS_N-1:HALF];
        if (&r_filt)                 w_cls = C_ALL;
        else if (w_any_l && w_any_r) w_cls = C_CENTER;
        else if (w_any_l)            w_cls = C_LEFT;
        else if (w_any_r)            w_cls = C_RIGHT;
        else                         w_cls = C_NONE;
    end

    side_t r_last_side;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_last_side <= SIDE_L;
        else if (w_cls == C_LEFT)  r_last_side <= SIDE_L;
        else if (w_cls == C_RIGHT) r_last_side <= SIDE_R;
    end

    // ---------------- state machine ----------------
    state_t        r_state, w_state_nx;
    logic [LW-1:0] r_lost_cnt;
    logic          w_timeout;

    assign w_timeout = (r_lost_cnt == LW'(LOST_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_lost_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state != S_SEARCH) r_lost_cnt <= '0;
            else                     r_lost_cnt <= r_lost_cnt + LW'(1);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (!en) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nx = S_FOLLOW;
                S_FOLLOW: begin
                    if (w_cls == C_ALL)       w_state_nx = S_STOP;
                    else if (w_cls == C_NONE) w_state_nx = S_SEARCH;
                end
                S_SEARCH: begin
                    if (w_cls == C_ALL || w_timeout) w_state_nx = S_STOP;
                    else if (w_cls != C_NONE)        w_state_nx = S_FOLLOW;
                end
                default:  w_state_nx = r_state;
            endcase
        end
    end

    // ---------------- wheel commands (rev = 1 means reverse) ----------------
    logic             w_rev_l, w_rev_r;
    logic [PWM_W-1:0] w_duty_l, w_duty_r;
    logic             w_halt;

    assign w_halt = (r_state == S_IDLE) || (r_state == S_STOP);

    always_comb begin
        w_rev_l  = 1'b0;
        w_rev_r  = 1'b0;
        w_duty_l = '0;
        w_duty_r = '0;
        if (r_state == S_FOLLOW) begin
            case (w_cls)
                C_CENTER: begin w_duty_l = duty_base; w_duty_r = duty_base; end
                C_LEFT:   begin w_duty_l = duty_turn; w_duty_r = duty_base; end
                C_RIGHT:  begin w_duty_l = duty_base; w_duty_r = duty_turn; end
                default:  ;
            endcase
        end else if (r_state == S_SEARCH) begin
            w_duty_l = duty_turn;
            w_duty_r = duty_turn;
            w_rev_l  = (r_last_side == SIDE_L);
            w_rev_r  = (r_last_side == SIDE_R);
        end
    end

    // ---------------- PWM ----------------
    logic [PWM_W-1:0] r_pwm_cnt, r_duty_l, r_duty_r;
    logic             r_rev_l, r_rev_r;
    logic             w_wrap;

    assign w_wrap = &r_pwm_cnt;

    // Commands are sampled only at the wrap; halting overrides the latched duty
    // immediately so the motor stops without waiting for the period to end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_duty_l  <= '0;
            r_duty_r  <= '0;
            r_rev_l   <= 1'b0;
            r_rev_r   <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (w_wrap) begin
                r_duty_l <= w_duty_l;
                r_duty_r <= w_duty_r;
                r_rev_l  <= w_rev_l;
                r_rev_r  <= w_rev_r;
            end
            if (w_halt) begin
                r_duty_l <= '0;
                r_duty_r <= '0;
            end
        end
    end

    logic w_gate_l, w_gate_r;

`ifdef LINE_TRACKER_DEADTIME_EN
    localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    logic [DW-1:0] r_dead_l, r_dead_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dead_l <= '0;
            r_dead_r <= '0;
        end else begin
            if (w_wrap && (w_rev_l != r_rev_l)) r_dead_l <= DW'(DEAD_CYC);
            else if (r_dead_l != '0)            r_dead_l <= r_dead_l - DW'(1);
            if (w_wrap && (w_rev_r != r_rev_r)) r_dead_r <= DW'(DEAD_CYC);
            else if (r_dead_r != '0)            r_dead_r <= r_dead_r - DW'(1);
        end
    end

    assign w_gate_l = (r_dead_l == '0);
    assign w_gate_r = (r_dead_r == '0);
`else
    assign w_gate_l = 1'b1;
    assign w_gate_r = 1'b1;
`endif

    // ---------------- registered H-bridge outputs ----------------
    logic       w_pwm_l, w_pwm_r;
    logic [3:0] r_motor;

    assign w_pwm_l = (r_pwm_cnt < r_duty_l) && w_gate_l;
    assign w_pwm_r = (r_pwm_cnt < r_duty_r) && w_gate_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_motor <= '0;
        end else if (w_halt) begin
            r_motor <= '0;
        end else begin
            r_motor[0] <= w_pwm_l & ~r_rev_l;
            r_motor[1] <= w_pwm_l &  r_rev_l;
            r_motor[2] <= w_pwm_r &  r_rev_r;
            r_motor[3] <= w_pwm_r & ~r_rev_r;
        end
    end

    assign motor = r_motor;
    assign state = r_state;
    assign lost  = (r_state == S_SEARCH);

endmodule

// File: tb/tb_line_tracker.sv
// Directed bench for line_tracker. u_dut uses a long search timeout so search
// behaviour can be observed over full PWM periods; u_to shares all stimulus but
// uses LOST_CYC=100 to exercise the timeout.
`timescale 1ns/1ps
module tb_line_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [3:0] sens = 4'b0000;
    logic [7:0] duty_base = 8'd200;
    logic [7:0] duty_turn = 8'd50;

    logic [3:0] motor_a, motor_b;
    logic [1:0] state_a, state_b;
    logic       lost_a, lost_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int c1, c2, c3, c4, cb, first2;
    logic ok, prev, glitch;

    always #5 clk = ~clk;

    line_tracker #(.SENS_N(4), .PWM_W(8), .FILT_LEN(4), .LOST_CYC(1000), .DEAD_CYC(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sens(sens),
        .duty_base(duty_base), .duty_turn(duty_turn),
        .motor(motor_a), .state(state_a), .lost(lost_a)
    );

    line_tracker #(.SENS_N(4), .PWM_W(8), .FILT_LEN(4), .LOST_CYC(100), .DEAD_CYC(16)) u_to (
        .clk(clk), .rst_n(rst_n), .en(en), .sens(sens),
        .duty_base(duty_base), .duty_turn(duty_turn),
        .motor(motor_b), .state(state_b), .lost(lost_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts high cycles per pin of u_dut, nonzero cycles of u_to, and the first
    // sample index at which IN2 of u_dut is high.
    task automatic measure(input int n);
        c1 = 0; c2 = 0; c3 = 0; c4 = 0; cb = 0; first2 = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c1 += int'(motor_a[0]);
            c2 += int'(motor_a[1]);
            c3 += int'(motor_a[2]);
            c4 += int'(motor_a[3]);
            cb += int'(motor_b != 4'b0000);
            if (motor_a[1] && first2 < 0) first2 = i;
        end
    endtask

    task automatic wait_rise_in1();
        ok = 1'b0;
        prev = motor_a[0];
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!prev && motor_a[0]) begin ok = 1'b1; break; end
            prev = motor_a[0];
        end
    endtask

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #20;
        check("rst_motor", motor_a, 0);
        check("rst_state", state_a, 0);
        check("rst_lost", lost_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3-sample glitch on sens[0] must never reach the filter output
        sens = 4'b0001;
        clocks(3);
        sens = 4'b0000;
        glitch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            glitch |= u_dut.r_filt[0];
        end
        check("glitch_blocked", glitch, 0);

        // stable change: appears on the 6th edge, not the 5th
        sens = 4'b0001;
        clocks(5);
        check("filt_edge5", u_dut.r_filt, 4'b0000);
        clocks(1);
        check("filt_edge6", u_dut.r_filt, 4'b0001);

        // FOLLOW centred
        sens = 4'b0110;
        clocks(10);
        check("filt_0110", u_dut.r_filt, 4'b0110);
        en = 1'b1;
        clocks(1);
        check("follow_state", state_a, 1);
        clocks(300);
        measure(256);
        check("center_in1", c1, 200);
        check("center_in4", c4, 200);
        check("center_in2_in3", c2 + c3, 0);

        // FOLLOW left correction
        sens = 4'b0011;
        clocks(300);
        measure(256);
        check("left_in1", c1, 50);
        check("left_in4", c4, 200);
        check("left_in2_in3", c2 + c3, 0);

        // line lost, entered at a known PWM phase
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u_dut.r_pwm_cnt == 8'd20) begin ok = 1'b1; break; end
        end
        check("sync_cnt20", ok, 1);
        sens = 4'b0000;
        clocks(6);
        check("search_edge6_still_follow", state_a, 1);
        clocks(1);
        check("search_state", state_a, 2);
        check("search_lost", lost_a, 1);
        check("to_search_state", state_b, 2);
        clocks(99);
        check("to_clk99_search", state_b, 2);
        clocks(1);
        check("to_clk100_stop", state_b, 3);
        check("main_still_search", state_a, 2);

        // first wrap after the state change: left wheel reverses
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u_dut.r_pwm_cnt == 8'd0) begin ok = 1'b1; break; end
        end
        check("sync_wrap", ok, 1);
        measure(256);
        check("rev_period_in1", c1, 0);
        check("rev_period_in4", c4, 50);
`ifdef LINE_TRACKER_DEADTIME_EN
        check("dead_in2_first", first2, 16);
        check("dead_in2_count", c2, 34);
`else
        check("nodead_in2_first", first2, 0);
        check("nodead_in2_count", c2, 50);
`endif
        check("to_motor_off_1", cb, 0);
        measure(256);
        check("search_in2", c2, 50);
        check("search_in4", c4, 50);
        check("search_in1_in3", c1 + c3, 0);
        check("to_motor_off_2", cb, 0);
        check("to_lost_low", lost_b, 0);

        // recovery
        sens = 4'b0110;
        clocks(6);
        check("recover_edge6", state_a, 2);
        clocks(1);
        check("recover_state", state_a, 1);
        check("recover_lost", lost_a, 0);
        check("to_stop_sticky", state_b, 3);

        // stop mark
        sens = 4'b1111;
        clocks(7);
        check("mark_stop", state_a, 3);
        measure(256);
        check("mark_motor_off", c1 + c2 + c3 + c4, 0);

        // STOP left only via IDLE
        sens = 4'b0110;
        clocks(10);
        check("stop_sticky", state_a, 3);
        en = 1'b0;
        clocks(1);
        check("en_low_idle", state_a, 0);
        check("en_low_idle_to", state_b, 0);
        en = 1'b1;
        clocks(1);
        check("en_high_follow", state_a, 1);
        check("en_high_follow_to", state_b, 1);

        // stop latency from the start of a high pulse
        clocks(300);
        wait_rise_in1();
        check("rise_found_1", ok, 1);
        en = 1'b0;
        clocks(1);
        check("stop_lat_state", state_a, 0);
        clocks(1);
        check("stop_lat_motor", motor_a, 0);

        // asynchronous reset mid-pulse
        en = 1'b1;
        clocks(300);
        wait_rise_in1();
        check("rise_found_2", ok, 1);
        clocks(3);
        check("pre_reset_active", motor_a[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_motor", motor_a, 0);
        check("async_rst_state", state_a, 0);
        check("async_rst_lost", lost_a, 0);
        check("async_rst_filt", u_dut.r_filt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/line_tracker.md
# line_tracker

Parametrised line-following motor controller for the smart-car chassis, generalising the two-sensor tracker to SENS_N sensors. It debounces the sensor array, classifies the line position, and runs a FOLLOW/SEARCH/STOP state machine. It generates its own per-wheel PWM and drives the 4-bit H-bridge input bus directly. It sits between the IR sensor pins and the motor driver.

## Interface
- SENS_N, 4: number of line sensors; even, ≥2; bit 0 is leftmost.
- PWM_W, 8: PWM counter/duty width; period 2^PWM_W clocks.
- FILT_LEN, 4: consecutive equal samples required to accept a sensor change; ≥1.
- LOST_CYC, 1000000: SEARCH timeout in clocks.
- DEAD_CYC, 16: dead-time clocks on a wheel direction reversal.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low forces IDLE.
- sens  in  SENS_N  raw sensor levels, 1 = line seen; asynchronous.
- duty_base  in  PWM_W  straight-ahead duty.
- duty_turn  in  PWM_W  inner-wheel duty when correcting or searching.
- motor  out  4  {IN4,IN3,IN2,IN1}: IN1 left fwd, IN2 left rev, IN3 right rev, IN4 right fwd.
- state  out  2  0 IDLE, 1 FOLLOW, 2 SEARCH, 3 STOP.
- lost  out  1  high while in SEARCH.

## Operation
- Input path: 2-FF synchroniser per sensor, then a per-bit filter. The filtered bit takes the synchronised value after FILT_LEN consecutive identical samples.
- Position classification on the filtered vector f. L means f[SENS_N/2-1:0] is nonzero; R means the upper half is nonzero.
  - ALL: f all ones.
  - CENTER: L and R, not ALL.
  - LEFT: L only.
  - RIGHT: R only.
  - NONE: f = 0.
- Side register: `last_side` records LEFT or RIGHT on each LEFT/RIGHT classification. Reset value is LEFT.
- State transitions:
  - IDLE → FOLLOW when en=1.
  - Any state → IDLE when en=0; this has priority.
  - FOLLOW → STOP on ALL.
  - FOLLOW → SEARCH on NONE; the lost counter clears.
  - SEARCH → FOLLOW on CENTER, LEFT or RIGHT.
  - SEARCH → STOP on ALL.
  - SEARCH → STOP when the lost counter reaches LOST_CYC-1.
  - STOP is left only via IDLE (en deasserted then reasserted).
- Wheel commands per state/class:
  - IDLE/STOP: both wheels off.
  - FOLLOW CENTER: both wheels forward at duty_base.
  - FOLLOW LEFT: left forward at duty_turn, right forward at duty_base.
  - FOLLOW RIGHT: mirror of LEFT.
  - SEARCH: the wheel on `last_side` reverses at duty_turn; the other wheel runs forward at duty_turn.
- PWM:
  - One free-running PWM_W-bit counter shared by both wheels.
  - Wheel output is high while counter < latched duty.
  - Duty 0 means always low; all-ones means high for 2^PWM_W−1 of 2^PWM_W clocks.
  - Duty and direction are latched only when the counter wraps to 0, so there are no runt pulses.
  - Exception: entry to IDLE/STOP zeroes outputs on the next edge without waiting for the wrap.
- Per wheel, the forward pin carries the PWM when direction = fwd and the reverse pin is 0, and vice versa. Both pins of one wheel are never high together.

## Timing
- Reset values: motor=4'b0000, state=0, lost=0. Counters, filters, synchronisers and `last_side` are all cleared.
- Reset assertion mid-run clears everything immediately, independent of clk.
- Sensor latency: a raw change held stable appears in f on the (2+FILT_LEN)th rising edge. The state register updates on the next edge.
- Wheel command latency: a new command takes effect at the first PWM wrap after the state/class update, then appears on motor 1 clock later (registered output).
- Stop latency: en low → motor=0 and state=0 two clocks later, regardless of PWM phase.
- Filter boundary: a glitch shorter than FILT_LEN samples never reaches f.
- Simultaneous events: ALL and timeout in the same cycle → STOP. en=0 overrides every transition.

## Configuration
- LINE_TRACKER_DEADTIME_EN defined: when a wheel's latched direction reverses, both its pins are held 0 for DEAD_CYC clocks starting at the wrap. PWM then resumes in the new direction, with the first period truncated.
- Undefined: direction reverses at the wrap with no gap.

## Test plan
- Reset: assert rst_n=0 mid-PWM with motor active → motor=0000, state=0, lost=0 immediately.
- Filter: with FILT_LEN=4, apply a 3-clock pulse on sens[0] → no class change. Apply a 4-clock-stable change → f updates on edge 6.
- Follow: en=1, sens=0110, duty_base=200, duty_turn=50 → state=1, IN1 and IN4 high 200/256 clocks per period, IN2=IN3=0. sens=0011 → IN1 duty 50, IN4 duty 200.
- Search/recover: from LEFT, sens=0000 → state=2, lost=1, IN2 and IN4 at duty 50. sens=0110 → state=1 within 2+FILT_LEN+1 clocks.
- Timeout/mark: sens=0000 held with LOST_CYC=100 → STOP at the 100th SEARCH clock, motor=0. Separately, sens=1111 in FOLLOW → STOP. en toggle 1→0→1 → FOLLOW.
- Dead-time (macro on, DEAD_CYC=16): FOLLOW→SEARCH reverses the left wheel → IN1=IN2=0 for 16 clocks after the wrap, then IN2 pulses. With the macro off → IN2 pulses from the wrap.
